// File: rtl/sram_wr_port_arbiter.sv
// Write-port owner for a reset-less 1R1W SRAM: clears every entry after reset, then arbitrates
// two valid/ready requesters. Define SRAM_WR_ARB_RR_EN for round-robin ties (default: fixed priority).
module sram_wr_port_arbiter #(
  parameter int unsigned           SRAM_DEPTH = 64,
  parameter int unsigned           SRAM_INDEX = 6,
  parameter int unsigned           SRAM_WIDTH = 32,
  parameter logic [SRAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic [SRAM_INDEX-1:0] req0_addr_i,
  input  logic [SRAM_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [SRAM_INDEX-1:0] req1_addr_i,
  input  logic [SRAM_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  init_busy_o,
  output logic                  we_o,
  output logic [SRAM_INDEX-1:0] addrWr_o,
  output logic [SRAM_WIDTH-1:0] data_o
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // One extra bit so the sweep counter cannot wrap before the last-entry compare.
  localparam logic [SRAM_INDEX:0] LastIdx = (SRAM_INDEX + 1)'(SRAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [SRAM_INDEX:0]   init_cnt_q, init_cnt_d;
  logic                  we_q, we_d;
  logic [SRAM_INDEX-1:0] addr_q, addr_d;
  logic [SRAM_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;

  logic run;
  logic grant;      // index of the requester that may hand off this cycle
  logic handshake;

  assign run = (state_q == StRun);

`ifdef SRAM_WR_ARB_RR_EN
  logic rr_ptr_q;

  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = rr_ptr_q;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else if (handshake) begin
      rr_ptr_q <= ~grant;
    end
  end
`else
  // Requester 0 always wins a tie.
  always_comb begin
    grant = 1'b0;
    if (!req0_valid_i && req1_valid_i) begin
      grant = 1'b1;
    end
  end
`endif

  assign req0_ready_o = run && req0_valid_i && !grant;
  assign req1_ready_o = run && req1_valid_i && grant;
  assign handshake    = req0_ready_o || req1_ready_o;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = (state_q == StInit);
    unique case (state_q)
      StInit: begin
        we_d       = 1'b1;
        addr_d     = init_cnt_q[SRAM_INDEX-1:0];
        data_d     = INIT_VALUE;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastIdx) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (handshake) begin
          we_d   = 1'b1;
          addr_d = grant ? req1_addr_i : req0_addr_i;
          data_d = grant ? req1_data_i : req0_data_i;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign we_o        = we_q;
  assign addrWr_o    = addr_q;
  assign data_o      = data_q;
  assign init_busy_o = busy_q;

endmodule

// File: tb/tb_sram_wr_port_arbiter.sv
// Self-checking bench for sram_wr_port_arbiter: directed sweeps, a vector table and random traffic
// against a cycle-count reference model.
module tb_sram_wr_port_arbiter;

  localparam int DEPTH = 64;
  localparam int IDX   = 6;
  localparam int W     = 32;
  localparam logic [W-1:0] INIT = '0;

  logic           clk = 1'b0;
  logic           reset;
  logic           v0, v1, r0, r1, busy, we;
  logic [IDX-1:0] a0, a1, addr;
  logic [W-1:0]   d0, d1, data;

  int checks = 0;
  int failures = 0;

  // Reference model: m_k counts non-reset edges since the last reset edge.
  int             m_k;
  logic           m_we;
  logic [IDX-1:0] m_addr;
  logic [W-1:0]   m_data;
  logic           m_pref;

  sram_wr_port_arbiter #(
    .SRAM_DEPTH(DEPTH),
    .SRAM_INDEX(IDX),
    .SRAM_WIDTH(W),
    .INIT_VALUE(INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid_i(v0),
    .req0_addr_i (a0),
    .req0_data_i (d0),
    .req0_ready_o(r0),
    .req1_valid_i(v1),
    .req1_addr_i (a1),
    .req1_data_i (d1),
    .req1_ready_o(r1),
    .init_busy_o (busy),
    .we_o        (we),
    .addrWr_o    (addr),
    .data_o      (data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_r0();
    logic run = (m_k >= DEPTH);
`ifdef SRAM_WR_ARB_RR_EN
    return run && v0 && (!v1 || !m_pref);
`else
    return run && v0;
`endif
  endfunction

  function automatic logic exp_r1();
    logic run = (m_k >= DEPTH);
`ifdef SRAM_WR_ARB_RR_EN
    return run && v1 && (!v0 || m_pref);
`else
    return run && v1 && !v0;
`endif
  endfunction

  task automatic model_check();
    chk("m_busy", {31'b0, busy}, {31'b0, (m_k <= DEPTH)});
    chk("m_we", {31'b0, we}, {31'b0, m_we});
    chk("m_addr", {26'b0, addr}, {26'b0, m_addr});
    chk("m_data", data, m_data);
    chk("m_ready0", {31'b0, r0}, {31'b0, exp_r0()});
    chk("m_ready1", {31'b0, r1}, {31'b0, exp_r1()});
  endtask

  task automatic model_step();
    logic g0, g1;
    g0 = exp_r0();
    g1 = exp_r1();
    if (reset) begin
      m_k = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_pref = 1'b0;
    end else if (m_k < DEPTH) begin
      m_we = 1'b1; m_addr = IDX'(m_k); m_data = INIT; m_k++;
    end else begin
      m_we = g0 || g1;
      if (g0) begin
        m_addr = a0; m_data = d0; m_pref = 1'b1;
      end else if (g1) begin
        m_addr = a1; m_data = d1; m_pref = 1'b0;
      end
      m_k++;
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Runs a full sweep from a fresh reset edge; ready0 may only rise once addr DEPTH-1 is out.
  task automatic sweep_check(input string tag);
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      chk({tag, "_we"}, {31'b0, we}, 32'd1);
      chk({tag, "_addr"}, {26'b0, addr}, i);
      chk({tag, "_data"}, data, INIT);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk({tag, "_ready0"}, {31'b0, r0}, {31'b0, (v0 && i == DEPTH - 1)});
      if (i != DEPTH - 1) cycle();
    end
  endtask

  typedef struct {
    logic           v0;
    logic [IDX-1:0] a0;
    logic [W-1:0]   d0;
    logic           v1;
    logic [IDX-1:0] a1;
    logic [W-1:0]   d1;
    logic           r0;
    logic           r1;
    logic           we;
    logic [IDX-1:0] addr;
    logic [W-1:0]   data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic acc0, acc1, both_first0;

    tbl[0] = '{0, 0, 0, 1, 3, 32'h33, 0, 1, 1, 3, 32'h33};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h33};
    tbl[2] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
`ifdef SRAM_WR_ARB_RR_EN
    tbl[3] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
`else
    tbl[3] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
`endif
    tbl[4] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
    tbl[5] = '{1, 7, 32'h77, 0, 0, 0, 1, 0, 1, 7, 32'h77};
`ifdef SRAM_WR_ARB_RR_EN
    tbl[6] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h22};
`else
    tbl[6] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11};
`endif

    reset = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    m_k = 0; m_we = 0; m_addr = 0; m_data = 0; m_pref = 0;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_addr", {26'b0, addr}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    cycle();

    // Sweep with req0 pending from the start; it lands just after the sweep.
    reset = 1'b0; v0 = 1'b1; a0 = 6'd5; d0 = 32'hA5A5A5A5;
    sweep_check("init");
    cycle();
    chk("post_init_we", {31'b0, we}, 32'd1);
    chk("post_init_addr", {26'b0, addr}, 32'd5);
    chk("post_init_data", data, 32'hA5A5A5A5);
    chk("post_init_busy", {31'b0, busy}, 32'd0);
    v0 = 1'b0;
    cycle();
    chk("idle_we", {31'b0, we}, 32'd0);
    chk("idle_addr_hold", {26'b0, addr}, 32'd5);

    // Reset while init_cnt is 30; the sweep must restart from 0.
    reset = 1'b1; cycle(); reset = 1'b0;
    v0 = 1'b1; a0 = 6'd9; d0 = 32'h0000_0909;
    cycle();
    for (int i = 0; i < 29; i++) cycle();
    chk("mid_addr29", {26'b0, addr}, 32'd29);
    reset = 1'b1;
    cycle();
    chk("mid_rst_we", {31'b0, we}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    sweep_check("resweep");
    cycle();
    chk("resweep_wr_addr", {26'b0, addr}, 32'd9);
    chk("resweep_wr_we", {31'b0, we}, 32'd1);

    // Both requesters held: alternation (RR) or req0 only (fixed).
    a0 = 6'd1; d0 = 32'h11; v1 = 1'b1; a1 = 6'd2; d1 = 32'h22;
    both_first0 = !m_pref;
    for (int j = 0; j < 6; j++) begin
      #1;
`ifdef SRAM_WR_ARB_RR_EN
      chk("tie_ready0", {31'b0, r0}, {31'b0, ((j % 2 == 0) == both_first0)});
      chk("tie_ready1", {31'b0, r1}, {31'b0, ((j % 2 == 0) != both_first0)});
`else
      chk("tie_ready0", {31'b0, r0}, 32'd1);
      chk("tie_ready1", {31'b0, r1}, 32'd0);
`endif
      cycle();
      chk("tie_we", {31'b0, we}, 32'd1);
    end
    v0 = 1'b0;
    #1;
    chk("tie_release_ready1", {31'b0, r1}, 32'd1);
    cycle();
    chk("tie_release_addr", {26'b0, addr}, 32'd2);
    v1 = 1'b0;

    // Vector table from a fresh sweep so the tie pointer starts at requester 0.
    reset = 1'b1; cycle(); reset = 1'b0;
    sweep_check("tblsweep");
    cycle();
    for (int i = 0; i < 8; i++) begin
      v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      #1;
      chk($sformatf("tbl%0d_ready0", i), {31'b0, r0}, {31'b0, tbl[i].r0});
      chk($sformatf("tbl%0d_ready1", i), {31'b0, r1}, {31'b0, tbl[i].r1});
      cycle();
      chk($sformatf("tbl%0d_we", i), {31'b0, we}, {31'b0, tbl[i].we});
      chk($sformatf("tbl%0d_addr", i), {26'b0, addr}, {26'b0, tbl[i].addr});
      chk($sformatf("tbl%0d_data", i), data, tbl[i].data);
    end

    // Random traffic; requesters hold their transaction until accepted.
    v0 = 0; v1 = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      #1;
      acc0 = r0;
      acc1 = r1;
      cycle();
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 9) < 6);
        a0 = IDX'($urandom_range(0, DEPTH - 1));
        d0 = $urandom;
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 9) < 6);
        a1 = IDX'($urandom_range(0, DEPTH - 1));
        d1 = $urandom;
      end
    end
    reset = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
